// File: rtl/riscv_defines.sv
// Shared exception cause codes and fault-responder enums.
package riscv_defines;

    localparam logic [4:0] EXC_CAUSE_INSTR_ACCESS = 5'd1;
    localparam logic [4:0] EXC_CAUSE_LOAD_ACCESS  = 5'd5;
    localparam logic [4:0] EXC_CAUSE_STORE_ACCESS = 5'd7;

    typedef enum logic {
        SRC_DATA  = 1'b0,
        SRC_INSTR = 1'b1
    } fault_src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } resp_state_e;

endpackage

// File: rtl/smartv_sat_counter.sv
// Saturating up-counter with synchronous clear; count updates one cycle after inc.
// Clear has priority over increment; at all-ones the count holds.
module smartv_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/smartv_fault_responder.sv
// Turns protection-unit data errors and prefetch faults into one precise exception; exc_req_o one cycle after the fault,
// data_err_ack_o one cycle after exc_ack_i. Faults arriving while an exception is outstanding are ignored.
module smartv_fault_responder
    import riscv_defines::*;
#(
    parameter int CNT_W      = 8,
    parameter int MAX_FAULTS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_req_i,
    input  logic [31:0]      data_addr_i,
    input  logic             data_we_i,
    input  logic             data_err_i,
    output logic             data_err_ack_o,
    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    input  logic             instr_fault_i,
    output logic             exc_req_o,
    output logic [4:0]       exc_cause_o,
    output logic [31:0]      exc_tval_o,
    input  logic             exc_ack_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] fault_cnt_o,
    output logic             lockout_o
);

    resp_state_e state;
    fault_src_e  src;
    logic [31:0] samp_addr;
    logic        samp_we;
    logic        capture;

    assign capture = (state == ST_IDLE) && (data_err_i || (instr_req_i && instr_fault_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            src            <= SRC_DATA;
            samp_addr      <= '0;
            samp_we        <= 1'b0;
            exc_req_o      <= 1'b0;
            exc_cause_o    <= '0;
            exc_tval_o     <= '0;
            data_err_ack_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // data_err_i lags its request by one cycle, so the sample taken
                    // last cycle is the one that belongs to the erroring access.
                    if (data_req_i) begin
                        samp_addr <= data_addr_i;
                        samp_we   <= data_we_i;
                    end
                    if (data_err_i) begin
                        state       <= ST_PEND;
                        src         <= SRC_DATA;
                        exc_req_o   <= 1'b1;
                        exc_cause_o <= samp_we ? EXC_CAUSE_STORE_ACCESS : EXC_CAUSE_LOAD_ACCESS;
                        exc_tval_o  <= samp_addr;
                    end else if (instr_req_i && instr_fault_i) begin
                        state       <= ST_PEND;
                        src         <= SRC_INSTR;
                        exc_req_o   <= 1'b1;
                        exc_cause_o <= EXC_CAUSE_INSTR_ACCESS;
                        exc_tval_o  <= instr_addr_i;
                    end
                end
                ST_PEND: begin
                    if (exc_ack_i) begin
                        exc_req_o   <= 1'b0;
                        exc_cause_o <= '0;
                        exc_tval_o  <= '0;
                        if (src == SRC_DATA) begin
                            state          <= ST_ACK;
                            data_err_ack_o <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ACK: begin
                    data_err_ack_o <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    smartv_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (capture),
        .clr   (clear_i),
        .count (fault_cnt_o)
    );

    assign lockout_o = (fault_cnt_o >= CNT_W'(MAX_FAULTS));

endmodule

// File: tb/tb_smartv_fault_responder.sv
// Directed bench: two responders (8-bit and 4-bit counters) share one stimulus stream.
module tb_smartv_fault_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req_i, data_we_i, data_err_i;
    logic [31:0] data_addr_i, instr_addr_i;
    logic        instr_req_i, instr_fault_i, exc_ack_i, clear_i;

    logic        data_err_ack_o, exc_req_o, lockout_o;
    logic [4:0]  exc_cause_o;
    logic [31:0] exc_tval_o;
    logic [7:0]  fault_cnt_o;

    logic        ack4, req4, lock4;
    logic [4:0]  cause4;
    logic [31:0] tval4;
    logic [3:0]  cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    smartv_fault_responder #(.CNT_W(8), .MAX_FAULTS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_err_i(data_err_i), .data_err_ack_o(data_err_ack_o),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_fault_i(instr_fault_i),
        .exc_req_o(exc_req_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o),
        .exc_ack_i(exc_ack_i), .clear_i(clear_i),
        .fault_cnt_o(fault_cnt_o), .lockout_o(lockout_o)
    );

    smartv_fault_responder #(.CNT_W(4), .MAX_FAULTS(12)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_err_i(data_err_i), .data_err_ack_o(ack4),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_fault_i(instr_fault_i),
        .exc_req_o(req4), .exc_cause_o(cause4), .exc_tval_o(tval4),
        .exc_ack_i(exc_ack_i), .clear_i(clear_i),
        .fault_cnt_o(cnt4), .lockout_o(lock4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"},   {31'd0, exc_req_o},      32'd0);
        chk({tag, "_cause"}, {27'd0, exc_cause_o},    32'd0);
        chk({tag, "_tval"},  exc_tval_o,              32'd0);
        chk({tag, "_ack"},   {31'd0, data_err_ack_o}, 32'd0);
    endtask

    // One instruction fault taken and retired; checks the exception is raised.
    task automatic instr_fault_round(input string tag, input logic [31:0] addr);
        instr_req_i = 1'b1; instr_addr_i = addr; instr_fault_i = 1'b1;
        step();
        chk({tag, "_req"},   {31'd0, exc_req_o},   32'd1);
        chk({tag, "_cause"}, {27'd0, exc_cause_o}, 32'd1);
        instr_req_i = 1'b0; instr_fault_i = 1'b0; exc_ack_i = 1'b1;
        step();
        exc_ack_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_err_i = 1'b0;
        instr_req_i = 1'b0; instr_addr_i = '0; instr_fault_i = 1'b0;
        exc_ack_i = 1'b0; clear_i = 1'b0;
        repeat (3) step();
        chk_idle("reset");
        chk("reset_cnt",  {24'd0, fault_cnt_o}, 32'd0);
        chk("reset_lock", {31'd0, lockout_o},   32'd0);
        rst_n = 1'b1;
        step();

        // Store fault at 0x3000
        data_req_i = 1'b1; data_addr_i = 32'h0000_3000; data_we_i = 1'b1;
        step();
        data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_err_i = 1'b1;
        step();
        chk("st_req",   {31'd0, exc_req_o},     32'd1);
        chk("st_cause", {27'd0, exc_cause_o},   32'd7);
        chk("st_tval",  exc_tval_o,             32'h3000);
        chk("st_cnt",   {24'd0, fault_cnt_o},   32'd1);
        step();
        chk("st_hold_req", {31'd0, exc_req_o},  32'd1);
        chk("st_noack",    {31'd0, data_err_ack_o}, 32'd0);
        exc_ack_i = 1'b1;
        step();
        exc_ack_i = 1'b0;
        chk("st_ack",     {31'd0, data_err_ack_o}, 32'd1);
        chk("st_ack_req", {31'd0, exc_req_o},      32'd0);
        chk("st_ack_cause", {27'd0, exc_cause_o},  32'd0);
        step();
        data_err_i = 1'b0;
        chk("st_ack_once", {31'd0, data_err_ack_o}, 32'd0);
        step();
        chk_idle("st_idle");
        chk("st_cnt_after", {24'd0, fault_cnt_o}, 32'd1);

        // Instruction fault at 0x800
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0800; instr_fault_i = 1'b1;
        step();
        instr_req_i = 1'b0; instr_addr_i = '0; instr_fault_i = 1'b0;
        chk("if_req",   {31'd0, exc_req_o},   32'd1);
        chk("if_cause", {27'd0, exc_cause_o}, 32'd1);
        chk("if_tval",  exc_tval_o,           32'h800);
        chk("if_cnt",   {24'd0, fault_cnt_o}, 32'd2);
        exc_ack_i = 1'b1;
        step();
        exc_ack_i = 1'b0;
        chk_idle("if_done");
        step();
        chk("if_noack", {31'd0, data_err_ack_o}, 32'd0);

        // Simultaneous load error at 0x2000 and instruction fault: data wins
        data_req_i = 1'b1; data_addr_i = 32'h0000_2000; data_we_i = 1'b0;
        step();
        data_req_i = 1'b0; data_err_i = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0900; instr_fault_i = 1'b1;
        step();
        chk("sim_cause", {27'd0, exc_cause_o}, 32'd5);
        chk("sim_tval",  exc_tval_o,           32'h2000);
        chk("sim_cnt",   {24'd0, fault_cnt_o}, 32'd3);
        // Further faults and a new store request while pending are ignored
        instr_addr_i = 32'h0000_0A00;
        data_req_i = 1'b1; data_addr_i = 32'h0000_4444; data_we_i = 1'b1;
        step();
        step();
        chk("pend_cause", {27'd0, exc_cause_o}, 32'd5);
        chk("pend_tval",  exc_tval_o,           32'h2000);
        chk("pend_cnt",   {24'd0, fault_cnt_o}, 32'd3);
        data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0;
        instr_req_i = 1'b0; instr_addr_i = '0; instr_fault_i = 1'b0;
        exc_ack_i = 1'b1;
        step();
        exc_ack_i = 1'b0;
        chk("sim_ack", {31'd0, data_err_ack_o}, 32'd1);
        step();
        data_err_i = 1'b0;
        step();
        chk_idle("sim_idle");
        chk("sim_cnt_after", {24'd0, fault_cnt_o}, 32'd3);

        // Drive the count to 15, then to the lockout threshold
        for (int i = 0; i < 12; i++) instr_fault_round("loop", 32'h1000 + 32'(i * 4));
        chk("cnt15",      {24'd0, fault_cnt_o}, 32'd15);
        chk("lock15",     {31'd0, lockout_o},   32'd0);
        chk("cnt4_15",    {28'd0, cnt4},        32'd15);
        chk("lock4_15",   {31'd0, lock4},       32'd1);
        instr_fault_round("f16", 32'h0000_1100);
        chk("cnt16",      {24'd0, fault_cnt_o}, 32'd16);
        chk("lock16",     {31'd0, lockout_o},   32'd1);
        // Lockout does not block capture; the 4-bit counter saturates
        for (int i = 0; i < 4; i++) instr_fault_round("post_lock", 32'h0000_1200);
        chk("cnt20",      {24'd0, fault_cnt_o}, 32'd20);
        chk("cnt4_sat",   {28'd0, cnt4},        32'd15);

        // Clear together with a new fault
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_1300; instr_fault_i = 1'b1; clear_i = 1'b1;
        step();
        instr_req_i = 1'b0; instr_fault_i = 1'b0; clear_i = 1'b0;
        chk("clr_req",   {31'd0, exc_req_o},   32'd1);
        chk("clr_cnt",   {24'd0, fault_cnt_o}, 32'd0);
        chk("clr_lock",  {31'd0, lockout_o},   32'd0);
        chk("clr_cnt4",  {28'd0, cnt4},        32'd0);
        exc_ack_i = 1'b1;
        step();
        exc_ack_i = 1'b0;
        instr_fault_round("after_clr", 32'h0000_1400);
        chk("after_clr_cnt", {24'd0, fault_cnt_o}, 32'd1);

        // Reset asserted while pending
        data_req_i = 1'b1; data_addr_i = 32'h0000_5000; data_we_i = 1'b1;
        step();
        data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_err_i = 1'b1;
        step();
        chk("rp_req",   {31'd0, exc_req_o},   32'd1);
        chk("rp_cause", {27'd0, exc_cause_o}, 32'd7);
        #2;
        rst_n = 1'b0;
        data_err_i = 1'b0;
        #1;
        chk_idle("rp_async");
        chk("rp_cnt", {24'd0, fault_cnt_o}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rp_noack", {31'd0, data_err_ack_o}, 32'd0);
            chk("rp_noreq", {31'd0, exc_req_o},      32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
